// File: rtl/fix_pkg.sv
// Shared Q16.16 fixed-point definitions: widths, clamp limits, the saturation
// helper reused by the add/sub/mul stages, and the skid-buffer state encoding.
package fix_pkg;

  localparam int FIX_W     = 32;
  localparam int FIX_SUM_W = 33;

  localparam logic [FIX_W-1:0] FIX_MAX = 32'h7FFF_FFFF;
  localparam logic [FIX_W-1:0] FIX_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_t;

  // The sum overflows Q16.16 when its two top bits disagree.
  function automatic logic fix_ovf(input logic signed [FIX_SUM_W-1:0] sum);
    return sum[FIX_SUM_W-1] ^ sum[FIX_W-1];
  endfunction

  function automatic logic signed [FIX_W-1:0] fix_sat(input logic signed [FIX_SUM_W-1:0] sum);
    logic signed [FIX_W-1:0] res;
    if (fix_ovf(sum)) begin
      res = sum[FIX_SUM_W-1] ? FIX_MIN : FIX_MAX;
    end else begin
      res = sum[FIX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fix_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: a main register that drives the
// output and a skid register that absorbs one extra beat while stalled.
module fix_skid_buf
  import fix_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         push, pop;

  assign in_ready  = (state_q != SKID_FULL) && !rst;
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      unique case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = SKID_FULL;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  // NOTE: the data registers are reset too because out_data must read zero during and after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/fix_sat_stage.sv
// Saturates the adder's 33-bit sum to Q16.16 and buffers it in a skid buffer.
// Define FIX_SAT_FLAG_EN to add the sat_flag / sat_sticky / sat_clr ports.
module fix_sat_stage
  import fix_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef FIX_SAT_FLAG_EN
  ,
  output logic              sat_flag,
  output logic              sat_sticky,
  input  logic              sat_clr
`endif
);

  logic [DATA_W-1:0] sat_val;

  assign sat_val = fix_sat(in_sum);

`ifdef FIX_SAT_FLAG_EN
  logic              ovf;
  logic [DATA_W:0]   buf_out;
  logic              sat_sticky_q, sat_sticky_d;

  assign ovf = fix_ovf(in_sum);

  fix_skid_buf #(.W(DATA_W + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({ovf, sat_val}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_data   = buf_out[DATA_W-1:0];
  assign sat_flag   = buf_out[DATA_W];
  assign sat_sticky = sat_sticky_q;

  // A flushed input is dropped, so it does not count as a clamp.
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    if (in_valid && in_ready && !flush && ovf) begin
      sat_sticky_d = 1'b1;
    end else if (sat_clr) begin
      sat_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_sticky_q <= 1'b0;
    end else begin
      sat_sticky_q <= sat_sticky_d;
    end
  end
`else
  fix_skid_buf #(.W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (sat_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );
`endif

endmodule
